regfile_wb_arbiter: RTL

- Shares the single register-file write port (16 x 19-bit, 1 write / 2 async reads) between NREQ writeback requesters: ALU, load unit, multiplier.
- Grants round-robin and registers the winning write into an output stage that drives the register file's we/rd_addr/wd.
- Keeps a 16-bit pending-write scoreboard so issue logic can stall reads of registers with writes in flight.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/regfile_wb_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and payload types for the writeback path.
package regfile_pkg;

  localparam int unsigned RF_AW   = 4;
  localparam int unsigned RF_DW   = 19;
  localparam int unsigned RF_REGS = 16;

  typedef logic [RF_AW-1:0] reg_addr_t;
  typedef logic [RF_DW-1:0] reg_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int unsigned j;

  // Walk offsets from farthest to nearest so the nearest valid index is the last written.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (32'(ptr) + 32'(i)) % N;
      if (req[j]) begin
        any = 1'b1;
        idx = IW'(j);
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the register-file write port plus pending-write scoreboard.
// Optional WB_BYPASS_EN adds forwarding of the committing write to the issue stage.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = RF_AW,
  parameter int unsigned DW   = RF_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [AW*NREQ-1:0]   req_addr,
  input  logic [DW*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 wb_hold,
  output logic                 wb_we,
  output logic [AW-1:0]        wb_addr,
  output logic [DW-1:0]        wb_data,
  input  logic                 rsv_valid,
  input  logic [AW-1:0]        rsv_addr,
  input  logic [AW-1:0]        rs1_addr,
  input  logic [AW-1:0]        rs2_addr,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 sb_waw
`ifdef WB_BYPASS_EN
  ,
  output logic                 rs1_fwd,
  output logic                 rs2_fwd,
  output logic [DW-1:0]        fwd_data
`endif
);

  localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NREG = RF_REGS;

  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gidx;
  logic [NREQ-1:0] gnt;
  logic            any_req;
  logic            grant_c;
  logic [IW-1:0]   ptr_nxt;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  logic [NREG-1:0] pending;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] pending_nxt;
  logic            waw_c;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (any_req)
  );

  assign grant_c   = any_req & ~wb_hold;
  assign req_ready = wb_hold ? '0 : gnt;
  assign ptr_nxt   = (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gidx == IW'(i)) begin
        sel_addr = req_addr[AW*i +: AW];
        sel_data = req_data[DW*i +: DW];
      end
    end
  end

  // Output stage: one registered write per granted cycle; address/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      rr_ptr  <= '0;
    end else if (grant_c) begin
      wb_we   <= 1'b1;
      wb_addr <= sel_addr;
      wb_data <= sel_data;
      rr_ptr  <= ptr_nxt;
    end else begin
      wb_we   <= 1'b0;
    end
  end

  // Scoreboard: clear applies first so a same-address reservation wins.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (rsv_valid) set_mask[rsv_addr] = 1'b1;
    if (wb_we)     clr_mask[wb_addr]  = 1'b1;
    pending_nxt = (pending & ~clr_mask) | set_mask;
    waw_c       = rsv_valid & pending[rsv_addr] & ~clr_mask[rsv_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      sb_waw  <= 1'b0;
    end else begin
      pending <= pending_nxt;
      sb_waw  <= waw_c;
    end
  end

`ifdef WB_BYPASS_EN
  assign rs1_fwd  = wb_we & (rs1_addr == wb_addr);
  assign rs2_fwd  = wb_we & (rs2_addr == wb_addr);
  assign fwd_data = wb_data;
  assign rs1_busy = pending[rs1_addr] & ~(rs1_fwd & ~set_mask[rs1_addr]);
  assign rs2_busy = pending[rs2_addr] & ~(rs2_fwd & ~set_mask[rs2_addr]);
`else
  // Register file still returns the old value during the commit cycle, so stay busy.
  assign rs1_busy = pending[rs1_addr];
  assign rs2_busy = pending[rs2_addr];
`endif

endmodule
